fft_result_reader: RTL

//  Drains FFT_TOP's frequency-bin result RAM once FFT_FINISH pulses.

---
 rtl/fft_result_reader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fft_result_reader.sv
// Reads the FFT result RAM in natural bin order once FFT_FINISH pulses and streams
// each bin over a valid/ready interface through a 2-entry skid FIFO.
module fft_result_reader #(
    parameter int N_POINTS    = 8,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = $clog2(N_POINTS),
    parameter int BIT_REVERSE = 1
) (
    input  logic                     CLK,
    input  logic                     nRESET,
    input  logic                     FFT_FINISH,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_real,
    input  logic signed [DATA_W-1:0] rd_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR_W-1:0]          r_rd_idx;
    logic                       r_vld_p1;
    logic [ADDR_W-1:0]          r_idx_p1;
    logic signed [DATA_W-1:0]   r_fifo_re  [2];
    logic signed [DATA_W-1:0]   r_fifo_im  [2];
    logic [ADDR_W-1:0]          r_fifo_idx [2];
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [1:0]                 r_count;
    logic                       r_overrun;

    logic                       w_pop;
    logic                       w_last_xfer;
    logic [1:0]                 w_occ;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < ADDR_W; i++) begin
            bitrev[i] = a[ADDR_W-1-i];
        end
    endfunction

    assign out_valid   = (r_count != 2'd0);
    assign out_real    = r_fifo_re[r_rd_ptr];
    assign out_imag    = r_fifo_im[r_rd_ptr];
    assign out_index   = r_fifo_idx[r_rd_ptr];
    assign out_last    = out_valid && (out_index == LAST_IDX);
    assign w_pop       = out_valid && out_ready;
    assign w_last_xfer = w_pop && out_last;

    // Occupancy credits the entry leaving this cycle, so a steady ready stream
    // can issue one read per cycle while never holding more than two bins.
    assign w_occ   = r_count - {1'b0, w_pop} + {1'b0, r_vld_p1};
    assign rd_en   = (r_state == S_READ) && (w_occ < 2'd2);
    assign rd_addr = (BIT_REVERSE != 0) ? bitrev(r_rd_idx) : r_rd_idx;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (FFT_FINISH) w_state_nxt = S_READ;
            S_READ:  if (rd_en && (r_rd_idx == LAST_IDX)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_xfer) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // p0: read issue; p1: RAM data returns and is pushed into the FIFO
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= S_IDLE;
            r_rd_idx  <= '0;
            r_vld_p1  <= 1'b0;
            r_idx_p1  <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_overrun <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_re[i]  <= '0;
                r_fifo_im[i]  <= '0;
                r_fifo_idx[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && FFT_FINISH) begin
                r_rd_idx <= '0;
            end else if (rd_en) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
            r_vld_p1 <= rd_en;
            r_idx_p1 <= r_rd_idx;
            if (r_vld_p1) begin
                r_fifo_re[r_wr_ptr]  <= rd_real;
                r_fifo_im[r_wr_ptr]  <= rd_imag;
                r_fifo_idx[r_wr_ptr] <= r_idx_p1;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_vld_p1} - {1'b0, w_pop};
            if (FFT_FINISH && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule
